// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the CAM request sequencer.
package cam_ctrl_pkg;

    localparam int unsigned KEY_W     = 8;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned CAM_DEPTH = 32;
    localparam int unsigned STAT_W    = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LKUP = 3'd1,
        CHK  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_e;

    typedef enum logic [STAT_W-1:0] {
        ST_HIT      = 2'd0,
        ST_MISS     = 2'd1,
        ST_INSERTED = 2'd2,
        ST_REJECT   = 2'd3
    } status_e;

endpackage

// File: rtl/cam_ctrl.sv
// Sequences lookup/insert requests onto a 32-entry CAM with a registered match
// output, allocating entries 1..31 in order and owning the CAM reset.
module cam_ctrl #(
    parameter int unsigned KEY_W = 8,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [KEY_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [IDX_W-1:0] used,
    output logic             cam_rst_n,
    output logic             cam_enable,
    output logic             cam_write,
    output logic [IDX_W-1:0] cam_addr,
    output logic [KEY_W-1:0] cam_data,
    input  logic [IDX_W-1:0] cam_out
);
    import cam_ctrl_pkg::*;

    localparam logic [IDX_W-1:0] USED_MAX = IDX_W'((2 ** IDX_W) - 1);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   used_q, used_d;
    logic [1:0]         status_q, status_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_q, req_ready_d;
    logic               cam_en_q, cam_en_d;
    logic               cam_wr_q, cam_wr_d;
    logic [IDX_W-1:0]   cam_addr_q, cam_addr_d;
    logic               cam_rst_n_q;

    // Next-state, datapath updates and registered-output preloads
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        used_d   = used_q;
        status_d = status_q;
        idx_d    = idx_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d  = req_op;
                    key_d = req_key;
                    // Key 0 would alias the CAM's zeroed, unallocated entries
                    if (req_key == '0) begin
                        state_d  = RSP;
                        status_d = ST_REJECT;
                        idx_d    = '0;
                    end else begin
                        state_d = LKUP;
                    end
                end
            end
            LKUP: state_d = CHK;
            CHK: begin
                if (cam_out != '0) begin
                    state_d  = RSP;
                    status_d = ST_HIT;
                    idx_d    = cam_out;
                end else if (!op_q) begin
                    state_d  = RSP;
                    status_d = ST_MISS;
                    idx_d    = '0;
                end else if (used_q == USED_MAX) begin
                    state_d  = RSP;
                    status_d = ST_REJECT;
                    idx_d    = '0;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                used_d   = IDX_W'(used_q + 1'b1);
                idx_d    = IDX_W'(used_q + 1'b1);
                status_d = ST_INSERTED;
                state_d  = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RSP);
        req_ready_d = (state_d == IDLE);
        cam_en_d    = (state_d == LKUP);
        cam_wr_d    = (state_d == WR);
        cam_addr_d  = (used_d == USED_MAX) ? '0 : IDX_W'(used_d + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            key_q       <= '0;
            used_q      <= '0;
            status_q    <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            cam_en_q    <= 1'b0;
            cam_wr_q    <= 1'b0;
            cam_addr_q  <= IDX_W'(1);
            cam_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            used_q      <= used_d;
            status_q    <= status_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            cam_en_q    <= cam_en_d;
            cam_wr_q    <= cam_wr_d;
            cam_addr_q  <= cam_addr_d;
            cam_rst_n_q <= 1'b1;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign rsp_idx    = idx_q;
    assign used       = used_q;
    assign cam_rst_n  = cam_rst_n_q;
    assign cam_enable = cam_en_q;
    assign cam_write  = cam_wr_q;
    assign cam_addr   = cam_addr_q;
    assign cam_data   = key_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM alongside the DUT, plus a queue-based
// model of the allocation table that predicts status, index and latency.
module tb_cam_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_key;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [4:0] rsp_idx;
    logic [4:0] used;
    logic       cam_rst_n;
    logic       cam_enable;
    logic       cam_write;
    logic [4:0] cam_addr;
    logic [7:0] cam_data;
    logic [4:0] cam_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model_q[$];
    logic [7:0] cam_mem[32];

    cam_ctrl #(.KEY_W(8), .IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_idx    (rsp_idx),
        .used       (used),
        .cam_rst_n  (cam_rst_n),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] cam_search(input logic [7:0] k);
        for (int i = 1; i < 32; i++)
            if (cam_mem[i] == k) return 5'(i);
        return 5'd0;
    endfunction

    // CAM: registered match, writes gated on a zero previous match, cleared by cam_rst_n
    always @(posedge clk) begin
        if (!cam_rst_n) begin
            for (int i = 0; i < 32; i++) cam_mem[i] <= 8'h00;
            cam_out <= 5'd0;
        end else begin
            if (cam_enable) cam_out <= cam_search(cam_data);
            if (cam_write && cam_out == 5'd0) cam_mem[cam_addr] <= cam_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_find(input logic [7:0] k);
        foreach (model_q[i]) if (model_q[i] == k) return i + 1;
        return 0;
    endfunction

    task automatic apply_reset(input int cycles);
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_used", used, 0);
        check("rst_status", rsp_status, 0);
        check("rst_idx", rsp_idx, 0);
        check("rst_cam_enable", cam_enable, 0);
        check("rst_cam_write", cam_write, 0);
        check("rst_cam_addr", cam_addr, 1);
        check("rst_cam_data", cam_data, 0);
        check("rst_cam_rst_n", cam_rst_n, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_cam_rst_n", cam_rst_n, 1);
        check("rel_req_ready", req_ready, 1);
        check("rel_rsp_valid", rsp_valid, 0);
        check("rel_used", used, 0);
        model_q.delete();
    endtask

    // One request end to end; expectations derived from the allocation table
    task automatic do_req(input logic op, input logic [7:0] key, input int hold);
        int exp_st, exp_idx, exp_lat, n, lat;
        bit exp_en, exp_wr, saw_en, saw_wr, both;
        logic [1:0] st0;
        logic [4:0] idx0;
        exp_en = (key != 8'h00);
        exp_wr = 1'b0;
        if (key == 8'h00) begin
            exp_st = 3; exp_idx = 0; exp_lat = 1;
        end else if (model_find(key) != 0) begin
            exp_st = 0; exp_idx = model_find(key); exp_lat = 3;
        end else if (!op) begin
            exp_st = 1; exp_idx = 0; exp_lat = 3;
        end else if (model_q.size() == 31) begin
            exp_st = 3; exp_idx = 0; exp_lat = 3;
        end else begin
            model_q.push_back(key);
            exp_st = 2; exp_idx = model_q.size(); exp_lat = 4; exp_wr = 1'b1;
        end

        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_key = key; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;

        saw_en = 0; saw_wr = 0; both = 0; lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (cam_enable) saw_en = 1;
            if (cam_write) saw_wr = 1;
            if (cam_enable && cam_write) both = 1;
            if (rsp_valid) break;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_status", rsp_status, exp_st);
        check("rsp_idx", rsp_idx, exp_idx);
        check("used", used, model_q.size());
        check("cam_addr", cam_addr, (model_q.size() == 31) ? 0 : model_q.size() + 1);
        check("saw_cam_enable", saw_en, exp_en);
        check("saw_cam_write", saw_wr, exp_wr);
        check("enable_and_write", both, 0);

        st0 = rsp_status; idx0 = rsp_idx;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, st0);
            check("hold_idx", rsp_idx, idx0);
            check("hold_req_ready", req_ready, 0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = 8'h00; rsp_ready = 1'b0;

        apply_reset(3);
        do_req(1'b0, 8'h5A, 0);
        do_req(1'b1, 8'h5A, 0);
        do_req(1'b1, 8'h3C, 0);
        do_req(1'b1, 8'h5A, 0);
        check("used_after_two", used, 2);
        do_req(1'b0, 8'h3C, 0);
        do_req(1'b0, 8'h00, 0);
        do_req(1'b1, 8'h00, 0);
        do_req(1'b0, 8'h5A, 10);

        // Fill every allocatable entry, then overflow
        apply_reset(3);
        for (int k = 1; k <= 31; k++) do_req(1'b1, 8'(k), 0);
        do_req(1'b1, 8'h20, 0);
        check("used_full", used, 31);
        do_req(1'b0, 8'h1F, 0);
        do_req(1'b0, 8'h20, 0);

        // Reset while the insert write is on the CAM pins
        apply_reset(3);
        req_valid = 1'b1; req_op = 1'b1; req_key = 8'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (n < 3) begin @(negedge clk); n++; end
        check("midwr_cam_write", cam_write, 1);
        check("midwr_cam_addr", cam_addr, 1);
        apply_reset(3);
        check("midwr_no_rsp", rsp_valid, 0);
        do_req(1'b0, 8'h77, 0);

        // Randomised traffic against the table model
        apply_reset(2);
        for (int r = 0; r < 60; r++) begin
            logic [7:0] k;
            k = 8'($urandom_range(0, 40));
            do_req(1'($urandom_range(0, 1)), k, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
